// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares the async-FIFO write port among NREQ packet sources.
// The grant is held for a whole packet, capped at MAXBEATS beats; wfull stalls the owner.
module fifo_write_arbiter #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4,
    parameter int MAXBEATS = 16,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(MAXBEATS + 1)
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     err_overlen,
    output logic [IDW-1:0]           err_id
);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic           state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  beat_cnt;
    logic [CW-1:0]  cnt_next;
    logic           sel_vld;
    logic [IDW-1:0] sel_idx;
    logic           accept;
    logic           owner_last;

    // First valid requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx     = 0;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!sel_vld && req_valid[idx]) begin
                sel_vld = 1'b1;
                sel_idx = IDW'(idx);
            end
        end
    end

    assign busy       = (state == BUSY);
    assign req_ready  = grant & {NREQ{~wfull}};
    assign winc       = (|(req_valid & grant)) && !wfull;
    assign accept     = winc;
    assign owner_last = req_last[owner];
    assign cnt_next   = beat_cnt + CW'(1);
    assign wdata      = busy ? req_data[owner*DATASIZE +: DATASIZE] : '0;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            err_overlen <= 1'b0;
            err_id      <= '0;
        end else begin
            err_overlen <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        grant    <= NREQ'(1) << sel_idx;
                        owner    <= sel_idx;
                        rr_ptr   <= (int'(sel_idx) == NREQ - 1) ? '0 : sel_idx + IDW'(1);
                        beat_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                default: begin
                    if (accept) begin
                        beat_cnt <= cnt_next;
                        if (owner_last) begin
                            state <= IDLE;
                            grant <= '0;
                        end else if (cnt_next == CW'(MAXBEATS)) begin
                            // Forced release: the rest of the packet must re-arbitrate.
                            state       <= IDLE;
                            grant       <= '0;
                            err_overlen <= 1'b1;
                            err_id      <= owner;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table plus multi-cycle corner sequences.
module tb_fifo_write_arbiter;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last  = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic        wfull = 1'b0;
    logic        winc;
    logic [7:0]  wdata;
    logic [3:0]  grant;
    logic        busy;
    logic        err_overlen;
    logic [1:0]  err_id;

    int total = 0;
    int bad   = 0;

    fifo_write_arbiter #(.DATASIZE(8), .NREQ(4), .MAXBEATS(16)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
        .wdata(wdata), .grant(grant), .busy(busy), .err_overlen(err_overlen),
        .err_id(err_id)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        f;
        logic [3:0]  e_grant;
        logic        e_winc;
        logic [7:0]  e_wdata;
        logic        e_busy;
        logic [3:0]  e_ready;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                                input logic f, input logic [3:0] eg, input logic ew,
                                input logic [7:0] ed, input logic eb, input logic [3:0] er);
        vec_t t;
        t.v = v; t.l = l; t.d = d; t.f = f;
        t.e_grant = eg; t.e_winc = ew; t.e_wdata = ed; t.e_busy = eb; t.e_ready = er;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                         input logic f);
        @(negedge wclk);
        req_valid = v;
        req_last  = l;
        req_data  = d;
        wfull     = f;
        #1;
    endtask

    initial begin
        int b;
        int errs;
        int eid;
        int bubbles;

        // single packet on req0, then req2 with wfull stalls and req0 as non-owner
        vecs[0]  = mk(4'b0001, 4'b0000, 32'h000000A1, 0, 4'b0000, 0, 8'h00, 0, 4'b0000);
        vecs[1]  = mk(4'b0001, 4'b0000, 32'h000000A1, 0, 4'b0001, 1, 8'hA1, 1, 4'b0001);
        vecs[2]  = mk(4'b0001, 4'b0000, 32'h000000A2, 0, 4'b0001, 1, 8'hA2, 1, 4'b0001);
        vecs[3]  = mk(4'b0001, 4'b0001, 32'h000000A3, 0, 4'b0001, 1, 8'hA3, 1, 4'b0001);
        vecs[4]  = mk(4'b0000, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h00, 0, 4'b0000);
        vecs[5]  = mk(4'b0100, 4'b0000, 32'h00B10000, 0, 4'b0000, 0, 8'h00, 0, 4'b0000);
        vecs[6]  = mk(4'b0100, 4'b0000, 32'h00B10000, 0, 4'b0100, 1, 8'hB1, 1, 4'b0100);
        vecs[7]  = mk(4'b0101, 4'b0000, 32'h00B20055, 1, 4'b0100, 0, 8'hB2, 1, 4'b0000);
        vecs[8]  = mk(4'b0101, 4'b0000, 32'h00B20055, 1, 4'b0100, 0, 8'hB2, 1, 4'b0000);
        vecs[9]  = mk(4'b0101, 4'b0000, 32'h00B20055, 1, 4'b0100, 0, 8'hB2, 1, 4'b0000);
        vecs[10] = mk(4'b0101, 4'b0000, 32'h00B20055, 0, 4'b0100, 1, 8'hB2, 1, 4'b0100);
        vecs[11] = mk(4'b0101, 4'b0000, 32'h00B30055, 0, 4'b0100, 1, 8'hB3, 1, 4'b0100);
        vecs[12] = mk(4'b0100, 4'b0100, 32'h00B40000, 0, 4'b0100, 1, 8'hB4, 1, 4'b0100);
        vecs[13] = mk(4'b0000, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h00, 0, 4'b0000);

        // reset state with all requesters asking
        drive(4'b1111, 4'b0000, 32'h44332211, 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_winc", 32'(winc), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_overlen), 0);
        chk("rst_errid", 32'(err_id), 0);
        @(negedge wclk);
        req_valid = '0;
        wrst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].f);
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            chk($sformatf("vec%0d_winc", i), 32'(winc), 32'(vecs[i].e_winc));
            chk($sformatf("vec%0d_wdata", i), 32'(wdata), 32'(vecs[i].e_wdata));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
        end

        // round robin from a fresh reset: 0,1,2,3,0,... with a bubble between packets
        @(negedge wclk);
        wrst = 1'b1;
        @(negedge wclk);
        wrst = 1'b0;
        for (int p = 0; p < 8; p++) begin
            drive(4'b1111, 4'b1111, 32'h13121110, 0);
            chk($sformatf("rr%0d_bubble", p), 32'(grant), 0);
            chk($sformatf("rr%0d_bwinc", p), 32'(winc), 0);
            drive(4'b1111, 4'b1111, 32'h13121110, 0);
            chk($sformatf("rr%0d_grant", p), 32'(grant), 32'(4'b0001 << (p % 4)));
            chk($sformatf("rr%0d_winc", p), 32'(winc), 1);
            chk($sformatf("rr%0d_wdata", p), 32'(wdata), 32'(8'h10 + p % 4));
        end
        drive(4'b0000, 4'b0000, 32'h0, 0);

        // overlength: 20-beat packet from req1 with MAXBEATS=16
        b = 1; errs = 0; eid = -1; bubbles = 0;
        for (int cyc = 0; cyc < 80 && b <= 20; cyc++) begin
            drive(4'b0010, (b == 20) ? 4'b0010 : 4'b0000, {16'h0, 8'(b), 8'h0}, 0);
            if (err_overlen) begin
                errs++;
                eid = int'(err_id);
            end
            if (winc) begin
                chk($sformatf("ovl_beat%0d", b), 32'(wdata), 32'(b));
                b++;
            end else if (grant == 4'b0000) begin
                bubbles++;
            end
        end
        drive(4'b0000, 4'b0000, 32'h0, 0);
        if (err_overlen) errs++;
        chk("ovl_writes", 32'(b - 1), 20);
        chk("ovl_errs", 32'(errs), 1);
        chk("ovl_errid", 32'(eid), 1);
        chk("ovl_bubbles", 32'(bubbles), 2);

        // req3 owns the port and stalls its valid while req0 waits
        drive(4'b1001, 4'b0000, 32'h31000001, 0);
        chk("gap_idle", 32'(grant), 0);
        drive(4'b1001, 4'b0000, 32'h31000001, 0);
        chk("gap_grant", 32'(grant), 32'(4'b1000));
        chk("gap_wdata", 32'(wdata), 32'h31);
        for (int g = 0; g < 5; g++) begin
            drive(4'b0001, 4'b0000, 32'h31000001, 0);
            chk($sformatf("gap%0d_grant", g), 32'(grant), 32'(4'b1000));
            chk($sformatf("gap%0d_winc", g), 32'(winc), 0);
            chk($sformatf("gap%0d_ready", g), 32'(req_ready), 32'(4'b1000));
        end
        drive(4'b1001, 4'b1000, 32'h32000001, 0);
        chk("gap_last_winc", 32'(winc), 1);
        chk("gap_last_wdata", 32'(wdata), 32'h32);
        drive(4'b0001, 4'b0001, 32'h00000001, 0);
        chk("gap_bubble", 32'(grant), 0);
        drive(4'b0001, 4'b0001, 32'h00000001, 0);
        chk("gap_req0_grant", 32'(grant), 32'(4'b0001));
        chk("gap_req0_wdata", 32'(wdata), 32'h01);

        // async reset during beat 2 of a req0 packet
        drive(4'b0001, 4'b0000, 32'h000000C1, 0);
        drive(4'b0001, 4'b0000, 32'h000000C1, 0);
        chk("ar_beat1", 32'(winc), 1);
        drive(4'b0001, 4'b0000, 32'h000000C2, 0);
        chk("ar_beat2", 32'(winc), 1);
        #2 wrst = 1'b1;
        #1;
        chk("ar_grant", 32'(grant), 0);
        chk("ar_winc", 32'(winc), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_errid", 32'(err_id), 0);
        @(negedge wclk);
        wrst = 1'b0;
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        req_data  = 32'h0000D2D1;
        #1;
        chk("ar_idle", 32'(grant), 0);
        drive(4'b0011, 4'b0011, 32'h0000D2D1, 0);
        chk("ar_rrptr0", 32'(grant), 32'(4'b0001));
        chk("ar_wdata", 32'(wdata), 32'hD1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the async FIFO write-clock domain (fifomem plus write-pointer/full logic) among NREQ requesters.
- Grants one requester at a time with round-robin fairness and packet atomicity: grant is held until the requester's last beat.
- Drives winc/wdata toward the FIFO and honours wfull backpressure.
- Enforces a maximum packet length per grant.

Parameters:
- DATASIZE, 8, FIFO data word width (matches fifomem DATASIZE).
- NREQ, 4, number of requesters (2..16).
- MAXBEATS, 16, maximum beats per grant before forced release (>=1).

Ports:
- wclk  input  1  write-domain clock.
- wrst  input  1  asynchronous active-high reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_last  input  NREQ  per-requester end-of-packet flag, qualified by req_valid.
- req_data  input  NREQ*DATASIZE  requester i occupies bits [i*DATASIZE +: DATASIZE].
- req_ready  output  NREQ  beat accepted this cycle when req_valid[i] && req_ready[i].
- wfull  input  1  FIFO full flag from write-pointer logic.
- winc  output  1  write strobe to the FIFO.
- wdata  output  DATASIZE  write data to the FIFO.
- grant  output  NREQ  one-hot current owner; zero when idle.
- busy  output  1  high while in BUSY state.
- err_overlen  output  1  one-cycle pulse on forced release.
- err_id  output  clog2(NREQ)  requester index of the last overlength event.

Behaviour:
- Reset (async, wrst=1) clears all state:
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
  - err_overlen=0, err_id=0, busy=0.
  - Combinational outputs then read winc=0, req_ready=0, wdata=0.
- Reset asserted mid-packet aborts the packet immediately. No partial state survives.
- Outputs are combinational from registered state:
  - wdata = req_data slice of the granted index, or 0 when idle.
  - req_ready[i] = grant[i] && !wfull.
  - winc = |(req_valid & grant) && !wfull.
  - winc is never high while wfull=1.
- States: IDLE and BUSY.
- IDLE:
  - If any req_valid is set, select the first set bit searching upward from rr_ptr, modulo NREQ.
  - At the clock edge: grant <= onehot(sel), rr_ptr <= (sel+1) mod NREQ, beat_cnt <= 0, state <= BUSY.
  - No write occurs in an IDLE cycle.
- Latency: req_valid first seen in cycle N gives grant and the earliest winc in cycle N+1.
- BUSY, each accepted beat (valid && ready of the owner):
  - beat_cnt increments.
  - If req_last=1, go to IDLE with grant <= 0.
  - Else if beat_cnt+1 == MAXBEATS, go to IDLE with grant <= 0, pulse err_overlen next cycle, err_id <= owner index.
  - Else remain BUSY.
- Release ordering: the release edge is the same edge that writes the final beat. Arbitration resumes in the following IDLE cycle. Exactly one bubble cycle separates packets.
- Owner drops req_valid mid-packet: grant is held indefinitely, winc=0, beat_cnt unchanged. There is no timeout.
- wfull=1 while BUSY: req_ready=0, winc=0, nothing is counted. Resumes the first cycle wfull=0.
- Non-owner req_valid is ignored; its req_ready stays 0.
- After a forced release, the remaining beats of that requester form a new packet that must re-arbitrate normally.
- beat_cnt width is clog2(MAXBEATS+1) and it never wraps.
- MAXBEATS=1: every beat is a forced release unless req_last=1 on that beat.
- rr_ptr wraps from NREQ-1 to 0.
- Requesters must hold req_data/req_last stable while valid && !ready. The arbiter does not register data.

Test Plan:
- Reset then single packet: req0 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd), wfull=0 -> grant=0001 one cycle after valid, winc high 3 cycles with those wdata values, then grant=0, busy=0.
- Round-robin contention: all 4 requesters continuously send 1-beat packets -> grant order 0,1,2,3,0,... with one idle cycle between grants and no requester served twice before others.
- Backpressure: wfull=1 for cycles 2-4 of a 4-beat packet from req2 -> winc=0 and req_ready=0 during those cycles; all 4 beats written in order, none duplicated.
- Overlength: MAXBEATS=16, req1 sends 20 beats with last on the 20th -> 16 writes, err_overlen pulses once with err_id=1, re-grant, remaining 4 beats written, no second error.
- Valid gap plus contention: req3 owns the grant and drops valid for 5 cycles while req0 is valid -> grant stays 1000, winc=0; req0 is granted only after req3's last beat.
- Async reset mid-packet: assert wrst during beat 2 of req0 -> grant/winc/busy drop immediately; after release, a new request from req0 is granted with rr_ptr starting at 0.
